// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and helpers for the CPU-to-memory bridge
//
// Purpose: state and access-width enums, the error read-data constant, and the
// funct3-to-width decode used by the request path.
// Ports: none (package mem_bridge_types).
package mem_bridge_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_bridge_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_t;

  localparam logic [31:0] MEM_BRIDGE_ERR_RDATA = 32'h0;

  // Only funct3[1:0] selects the width; bit 2 (unsigned loads) is the
  // core's concern. Codes x11 and 11x all fall into the word bucket.
  function automatic mem_width_t width_of(input logic [2:0] funct3);
    mem_width_t w;
    casez (funct3)
      3'b?00:  w = BYTE;
      3'b?01:  w = HALF;
      default: w = WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane mask, store-data shift and alignment check
//
// Purpose: purely combinational lane steering for one access.
// Ports:
//   i_width         access width (byte/half/word)
//   i_off           byte offset within the word, address[1:0]
//   i_wdata         unshifted store data
//   o_byte_enable   lane mask
//   o_wdata_shifted store data moved to its lanes
//   o_misaligned    access straddles its natural alignment
module mem_align
  import mem_bridge_types::*;
(
  input  mem_width_t  i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_byte_enable,
  output logic [31:0] o_wdata_shifted,
  output logic        o_misaligned
);

  always_comb begin
    o_byte_enable   = 4'b1111;
    o_misaligned    = 1'b0;
    o_wdata_shifted = i_wdata << {i_off, 3'b000};
    case (i_width)
      BYTE: begin
        o_byte_enable = 4'b0001 << i_off;
      end
      HALF: begin
        o_byte_enable = 4'b0011 << i_off;
        o_misaligned  = i_off[0];
      end
      default: begin
        o_byte_enable = 4'b1111;
        o_misaligned  = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU load/store to word-aligned memory port bridge
//
// Purpose: accepts a level-held read/write request, issues a word-aligned
// memory access with lane mask and shifted store data, waits for mem_resp and
// returns right-justified load data with a one-cycle cpu_resp pulse.
// Misaligned requests complete immediately without touching memory.
// Optional build macro: MEM_BRIDGE_TIMEOUT_EN (abort BUSY after
// TIMEOUT_CYCLES cycles with err=1).
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   cpu_read/cpu_write  request levels (write wins if both)
//   cpu_funct3          access width code
//   cpu_address         byte address
//   cpu_wdata           unshifted store data
//   cpu_rdata           right-justified load data
//   cpu_resp            completion pulse
//   misaligned, err     completion qualifiers
//   mem_read/mem_write  registered memory strobes
//   mem_address         word-aligned address
//   mem_wdata           lane-shifted store data
//   mem_byte_enable     lane mask
//   mem_rdata, mem_resp memory read data and completion
module mem_bridge
  import mem_bridge_types::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp,
  output logic        misaligned,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  mem_bridge_state_t r_state, w_state_nx;

  logic [31:0] r_cpu_rdata,  w_cpu_rdata_nx;
  logic        r_cpu_resp,   w_cpu_resp_nx;
  logic        r_misaligned, w_misaligned_nx;
  logic        r_mem_read,   w_mem_read_nx;
  logic        r_mem_write,  w_mem_write_nx;
  logic [31:0] r_mem_address, w_mem_address_nx;
  logic [31:0] r_mem_wdata,  w_mem_wdata_nx;
  logic [3:0]  r_mem_be,     w_mem_be_nx;
  logic [1:0]  r_off,        w_off_nx;
  mem_width_t  r_width,      w_width_nx;
  logic        r_is_write,   w_is_write_nx;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nx;
  logic             r_err,     w_err_nx;
`endif

  mem_width_t  w_req_width;
  logic [3:0]  w_req_be;
  logic [31:0] w_req_wdata;
  logic        w_req_misaligned;
  logic        w_req;
  logic [31:0] w_load_data;

  assign w_req_width = width_of(cpu_funct3);
  assign w_req       = cpu_read | cpu_write;

  mem_align u_align (
    .i_width         (w_req_width),
    .i_off           (cpu_address[1:0]),
    .i_wdata         (cpu_wdata),
    .o_byte_enable   (w_req_be),
    .o_wdata_shifted (w_req_wdata),
    .o_misaligned    (w_req_misaligned)
  );

  // Word loads are aligned so no shift is needed; narrower loads bring the
  // addressed lane down to bit 0 and leave the upper bytes for the core.
  assign w_load_data = (r_width == WORD) ? mem_rdata
                                         : (mem_rdata >> {r_off, 3'b000});

  always_comb begin
    w_state_nx       = r_state;
    w_cpu_rdata_nx   = r_cpu_rdata;
    w_cpu_resp_nx    = 1'b0;
    w_misaligned_nx  = 1'b0;
    w_mem_read_nx    = r_mem_read;
    w_mem_write_nx   = r_mem_write;
    w_mem_address_nx = r_mem_address;
    w_mem_wdata_nx   = r_mem_wdata;
    w_mem_be_nx      = r_mem_be;
    w_off_nx         = r_off;
    w_width_nx       = r_width;
    w_is_write_nx    = r_is_write;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    w_tmo_cnt_nx     = r_tmo_cnt;
    w_err_nx         = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_mem_address_nx = {cpu_address[31:2], 2'b00};
          w_mem_wdata_nx   = w_req_wdata;
          w_mem_be_nx      = w_req_be;
          w_off_nx         = cpu_address[1:0];
          w_width_nx       = w_req_width;
          w_is_write_nx    = cpu_write;
          if (w_req_misaligned) begin
            w_state_nx      = RESP;
            w_cpu_resp_nx   = 1'b1;
            w_misaligned_nx = 1'b1;
            w_cpu_rdata_nx  = MEM_BRIDGE_ERR_RDATA;
          end else begin
            w_state_nx     = BUSY;
            w_mem_write_nx = cpu_write;
            w_mem_read_nx  = ~cpu_write;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            w_tmo_cnt_nx   = '0;
`endif
          end
        end
      end

      BUSY: begin
        if (mem_resp) begin
          w_state_nx     = RESP;
          w_cpu_resp_nx  = 1'b1;
          w_mem_read_nx  = 1'b0;
          w_mem_write_nx = 1'b0;
          if (!r_is_write) begin
            w_cpu_rdata_nx = w_load_data;
          end
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nx     = RESP;
          w_cpu_resp_nx  = 1'b1;
          w_err_nx       = 1'b1;
          w_mem_read_nx  = 1'b0;
          w_mem_write_nx = 1'b0;
          w_cpu_rdata_nx = MEM_BRIDGE_ERR_RDATA;
        end else begin
          w_tmo_cnt_nx = r_tmo_cnt + 1'b1;
        end
`endif
      end

      RESP: begin
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx     = IDLE;
        w_mem_read_nx  = 1'b0;
        w_mem_write_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cpu_rdata   <= '0;
      r_cpu_resp    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_off         <= '0;
      r_width       <= BYTE;
      r_is_write    <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nx;
      r_cpu_rdata   <= w_cpu_rdata_nx;
      r_cpu_resp    <= w_cpu_resp_nx;
      r_misaligned  <= w_misaligned_nx;
      r_mem_read    <= w_mem_read_nx;
      r_mem_write   <= w_mem_write_nx;
      r_mem_address <= w_mem_address_nx;
      r_mem_wdata   <= w_mem_wdata_nx;
      r_mem_be      <= w_mem_be_nx;
      r_off         <= w_off_nx;
      r_width       <= w_width_nx;
      r_is_write    <= w_is_write_nx;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      r_tmo_cnt     <= w_tmo_cnt_nx;
      r_err         <= w_err_nx;
`endif
    end
  end

  assign cpu_rdata       = r_cpu_rdata;
  assign cpu_resp        = r_cpu_resp;
  assign misaligned      = r_misaligned;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - self-checking bench for mem_bridge
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
  logic        cpu_resp, misaligned, err;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_funct3      (cpu_funct3),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_resp        (cpu_resp),
    .misaligned      (misaligned),
    .err             (err),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {27'd0, cpu_resp, misaligned, err, mem_read, mem_write}, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_be"}, {28'd0, mem_byte_enable}, 32'd0);
    check({tag, "_rdata"}, cpu_rdata, 32'd0);
  endtask

  // One complete transaction. Expectations come from lane arithmetic:
  // the access covers bytes [off, off+size), store bytes move up by off,
  // load bytes move down by off.
  task automatic txn(input bit wr, input bit both, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rdv, input int nwait);
    int          size, off;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] ew, er, ea;
    off  = int'(addr[1:0]);
    size = f3[1] ? 4 : (f3[0] ? 2 : 1);
    mis  = (off % size) != 0;
    be = '0; ew = '0; er = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) be[i] = 1'b1;
      if (i >= off) ew[8*i +: 8] = wd[8*(i-off) +: 8];
      if (i + off < 4) er[8*i +: 8] = rdv[8*(i+off) +: 8];
    end
    ea = {addr[31:2], 2'b00};

    @(negedge clk);
    cpu_write   = wr;
    cpu_read    = !wr || both;
    cpu_funct3  = f3;
    cpu_address = addr;
    cpu_wdata   = wd;
    mem_resp    = 1'b0;
    @(posedge clk); #1;

    if (mis) begin
      check("mis_resp", {31'd0, cpu_resp}, 32'd1);
      check("mis_flag", {31'd0, misaligned}, 32'd1);
      check("mis_nostrobe", {30'd0, mem_read, mem_write}, 32'd0);
      check("mis_rdata", cpu_rdata, 32'd0);
      check("mis_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      cpu_read = 1'b0; cpu_write = 1'b0;
      @(posedge clk); #1;
      check("mis_after", {29'd0, cpu_resp, mem_read, mem_write}, 32'd0);
    end else begin
      check("strobe", {30'd0, mem_read, mem_write}, wr ? 32'd1 : 32'd2);
      check("addr", mem_address, ea);
      check("be", {28'd0, mem_byte_enable}, {28'd0, be});
      check("wdata", mem_wdata, ew);
      check("early_resp", {31'd0, cpu_resp}, 32'd0);
      for (int w = 0; w < nwait; w++) begin
        @(negedge clk);
        mem_rdata = $urandom;
        mem_resp  = 1'b0;
        @(posedge clk); #1;
        check("hold_strobe", {30'd0, mem_read, mem_write}, wr ? 32'd1 : 32'd2);
        check("hold_addr", mem_address, ea);
        check("hold_wdata", mem_wdata, ew);
        check("hold_noresp", {31'd0, cpu_resp}, 32'd0);
      end
      @(negedge clk);
      mem_rdata = rdv;
      mem_resp  = 1'b1;
      @(posedge clk); #1;
      check("resp", {31'd0, cpu_resp}, 32'd1);
      check("resp_nostrobe", {30'd0, mem_read, mem_write}, 32'd0);
      check("resp_flags", {30'd0, misaligned, err}, 32'd0);
      if (!wr) check("rdata", cpu_rdata, er);
      @(negedge clk);
      mem_resp  = 1'b0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      @(posedge clk); #1;
      check("resp_pulse", {31'd0, cpu_resp}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_funct3 = 3'd0;
    cpu_address = '0; cpu_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    txn(1'b0, 1'b0, 3'b010, 32'h0000_1004, 32'h0,         32'hCAFE_BABE, 0);
    txn(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0,         0);
    txn(1'b0, 1'b0, 3'b001, 32'h0000_3002, 32'h0,         32'h8001_1234, 1);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h1111_2222, 32'h0,         0);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_5000, 32'h1234_BEEF, 32'h0,         5);
    txn(1'b0, 1'b0, 3'b100, 32'h0000_6003, 32'h0,         32'h9A78_5634, 2);
    txn(1'b0, 1'b0, 3'b011, 32'h0000_7000, 32'h0,         32'h0BAD_F00D, 0);
    txn(1'b0, 1'b0, 3'b111, 32'h0000_7002, 32'h0,         32'h0,         0);
    txn(1'b1, 1'b1, 3'b001, 32'h0000_8002, 32'h0000_C3C3, 32'h0,         1);
    txn(1'b0, 1'b0, 3'b101, 32'h0000_9003, 32'h0,         32'h0,         0);

    // Reset in the middle of BUSY, then a stale mem_resp.
    @(negedge clk);
    cpu_write = 1'b1; cpu_read = 1'b0; cpu_funct3 = 3'b001;
    cpu_address = 32'h0000_5000; cpu_wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    check("rst_busy_strobe", {30'd0, mem_read, mem_write}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cpu_write = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    mem_resp = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("late_resp", {29'd0, cpu_resp, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    mem_resp = 1'b0;
    @(posedge clk); #1;
    check("late_resp2", {29'd0, cpu_resp, mem_read, mem_write}, 32'd0);
    check("late_rdata", cpu_rdata, 32'd0);

    for (int k = 0; k < 60; k++) begin
      bit wr, both;
      wr   = 1'($urandom_range(0, 1));
      both = wr & 1'($urandom_range(0, 1));
      txn(wr, both, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)));
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_funct3 = 3'b010;
    cpu_address = 32'h0000_A000; mem_resp = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      check("tmo_hold", {30'd0, mem_read, mem_write}, 32'd2);
    end
    @(posedge clk); #1;
    check("tmo_resp", {31'd0, cpu_resp}, 32'd1);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_drop", {30'd0, mem_read, mem_write}, 32'd0);
    check("tmo_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    check("tmo_pulse", {30'd0, cpu_resp, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
